// File: rtl/exe_stage_mc.sv
// Multi-cycle execute stage: 1-cycle ALU ops, counter-timed MUL, restoring DIVU/REMU.
// Valid/ready on both sides; one registered result slot on the output.
module exe_stage_mc #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             dbz,
    output logic             busy
);

    localparam int LG   = $clog2(WIDTH);
    localparam int CMAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t           r_state, w_state_n;
    logic [CW-1:0]    r_cnt, w_cnt_n;
    logic [WIDTH-1:0] r_opa, w_opa_n;
    logic [WIDTH-1:0] r_opb, w_opb_n;
    logic [WIDTH-1:0] r_q, w_q_n;
    logic [WIDTH-1:0] r_rem, w_rem_n;
    logic             r_is_rem, w_is_rem_n;
    logic [WIDTH-1:0] r_result, w_result_n;
    logic             r_out_valid, w_out_valid_n;
    logic             r_dbz, w_dbz_n;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_mul;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_sub;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_load;
    logic [WIDTH-1:0] w_load_val;
    logic             w_load_dbz;

    assign in_ready   = !rst && (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_is_mul   = (control == 4'h8);
    assign w_is_div   = (control == 4'h9) || (control == 4'hA);
    assign out_valid  = r_out_valid;
    assign alu_result = r_result;
    assign zero       = (r_result == '0);
    assign dbz        = r_dbz;
    assign busy       = (r_state != S_IDLE);

    always_comb begin
        w_alu = '0;
        case (control)
            4'h0: w_alu = a & b;
            4'h1: w_alu = a | b;
            4'h2: w_alu = a + b;
            4'h3: w_alu = a ^ b;
            4'h4: w_alu = a << b[LG-1:0];
            4'h5: w_alu = a >> b[LG-1:0];
            4'h6: w_alu = a - b;
            4'h7: w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'h8: w_alu = a * b;
            4'hC: w_alu = ~(a | b);
            default: w_alu = '0;
        endcase
    end

    // One restoring step: shift in next dividend bit, subtract if it fits.
    assign w_mul       = r_opa * r_opb;
    assign w_div_shift = {r_rem, r_q[WIDTH-1]};
    assign w_div_sub   = w_div_shift - {1'b0, r_opb};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    assign w_rem_next  = w_div_ge ? w_div_sub[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_q_next    = {r_q[WIDTH-2:0], w_div_ge};

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_opa_n    = r_opa;
        w_opb_n    = r_opb;
        w_q_n      = r_q;
        w_rem_n    = r_rem;
        w_is_rem_n = r_is_rem;
        w_load     = 1'b0;
        w_load_val = '0;
        w_load_dbz = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul && (MUL_LATENCY > 1)) begin
                        w_state_n = S_MUL;
                        w_cnt_n   = CW'(MUL_LATENCY - 1);
                        w_opa_n   = a;
                        w_opb_n   = b;
                    end else if (w_is_div && (b != '0)) begin
                        w_state_n  = S_DIV;
                        w_cnt_n    = CW'(WIDTH);
                        w_q_n      = a;
                        w_rem_n    = '0;
                        w_opb_n    = b;
                        w_is_rem_n = (control == 4'hA);
                    end else if (w_is_div) begin
                        w_load     = 1'b1;
                        w_load_val = (control == 4'hA) ? a : '1;
                        w_load_dbz = 1'b1;
                    end else begin
                        w_load     = 1'b1;
                        w_load_val = w_alu;
                    end
                end
            end
            S_MUL: begin
                if (r_cnt == CW'(1)) begin
                    w_load     = 1'b1;
                    w_load_val = w_mul;
                    w_state_n  = S_IDLE;
                    w_cnt_n    = '0;
                end else begin
                    w_cnt_n = r_cnt - CW'(1);
                end
            end
            S_DIV: begin
                w_q_n   = w_q_next;
                w_rem_n = w_rem_next;
                if (r_cnt == CW'(1)) begin
                    w_load     = 1'b1;
                    w_load_val = r_is_rem ? w_rem_next : w_q_next;
                    w_state_n  = S_IDLE;
                    w_cnt_n    = '0;
                end else begin
                    w_cnt_n = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
        endcase

        // A new result always wins over a draining transfer.
        w_result_n    = r_result;
        w_dbz_n       = r_dbz;
        w_out_valid_n = r_out_valid;
        if (w_load) begin
            w_result_n    = w_load_val;
            w_dbz_n       = w_load_dbz;
            w_out_valid_n = 1'b1;
        end else if (r_out_valid && out_ready) begin
            w_out_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_is_rem    <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_opa       <= w_opa_n;
            r_opb       <= w_opb_n;
            r_q         <= w_q_n;
            r_rem       <= w_rem_n;
            r_is_rem    <= w_is_rem_n;
            r_result    <= w_result_n;
            r_out_valid <= w_out_valid_n;
            r_dbz       <= w_dbz_n;
        end
    end

endmodule
